// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C FRAM-style target.
package i2c_target_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEVADDR,
        ACK_DEV,
        WADDR,
        ACK_WADDR,
        WDATA,
        ACK_WDATA,
        RDATA,
        MACK,
        IGNORE
    } i2c_tgt_state_t;

    localparam logic       I2C_ACK       = 1'b0;
    localparam logic       I2C_NACK      = 1'b1;
    localparam logic [6:0] DEV_ADDR_FM24 = 7'h50;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges and START/STOP conditions.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_h;
    logic       sda_h;

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_h    <= scl_sync[1];
            sda_h    <= sda_sync[1];
        end
    end

    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_h;
    assign scl_fall  = ~scl_sync[1] & scl_h;
    assign start_det = scl_sync[1] & scl_h & sda_h & ~sda_sync[1];
    assign stop_det  = scl_sync[1] & scl_h & ~sda_h & sda_sync[1];

endmodule

// File: rtl/i2c_fram_target.sv
// I2C target emulating a byte-addressed FRAM with on-chip storage and a write-commit strobe.
module i2c_fram_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = DEV_ADDR_FM24,
    parameter int         MEM_BYTES = 256,
    parameter int         ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              sda_t,
    output logic              busy,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int                MEM_AW   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [ADDR_W-1:0] PTR_MASK = ADDR_W'(MEM_BYTES - 1);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    i2c_tgt_state_t    state, state_next;
    logic [2:0]        bit_cnt, bit_cnt_next;
    logic              byte_done, byte_done_next;
    logic [7:0]        shift, shift_next;
    logic              rw, rw_next;
    logic [ADDR_W-1:0] ptr, ptr_next, ptr_inc;
    logic              sda_t_next, busy_next, wr_strobe_next;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [7:0]        wr_data_next;
    logic              mem_we;
    logic [7:0]        mem [MEM_BYTES];
    logic [7:0]        mem_rd;

    assign sda_o   = 1'b0;
    assign mem_rd  = mem[ptr[MEM_AW-1:0]];
    assign ptr_inc = (ptr + ADDR_W'(1)) & PTR_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            shift     <= 8'h00;
            rw        <= 1'b0;
            ptr       <= '0;
            sda_t     <= 1'b1;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= 8'h00;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            byte_done <= byte_done_next;
            shift     <= shift_next;
            rw        <= rw_next;
            ptr       <= ptr_next;
            sda_t     <= sda_t_next;
            busy      <= busy_next;
            wr_strobe <= wr_strobe_next;
            wr_addr   <= wr_addr_next;
            wr_data   <= wr_data_next;
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr[MEM_AW-1:0]] <= shift;
        end
    end

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        byte_done_next = byte_done;
        shift_next     = shift;
        rw_next        = rw;
        ptr_next       = ptr;
        sda_t_next     = sda_t;
        busy_next      = busy;
        wr_strobe_next = 1'b0;
        wr_addr_next   = wr_addr;
        wr_data_next   = wr_data;
        mem_we         = 1'b0;

        if (stop_det) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            sda_t_next = 1'b1;
        end else if (start_det) begin
            state_next     = DEVADDR;
            bit_cnt_next   = 3'd0;
            byte_done_next = 1'b0;
            sda_t_next     = 1'b1;
        end else begin
            case (state)
                // byte_done separates "8 bits received" from "no bits yet", since the counter wraps.
                DEVADDR, WADDR, WDATA: begin
                    if (scl_rise) begin
                        shift_next   = {shift[6:0], sda_s};
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done_next = 1'b1;
                        end
                    end else if (scl_fall && byte_done) begin
                        bit_cnt_next   = 3'd0;
                        byte_done_next = 1'b0;
                        sda_t_next     = I2C_ACK;
                        case (state)
                            DEVADDR: begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    state_next = ACK_DEV;
                                    busy_next  = 1'b1;
                                    rw_next    = shift[0];
                                end else begin
                                    state_next = IGNORE;
                                    busy_next  = 1'b0;
                                    sda_t_next = I2C_NACK;
                                end
                            end
                            WADDR: begin
                                ptr_next   = ADDR_W'(shift) & PTR_MASK;
                                state_next = ACK_WADDR;
                            end
                            default: begin
                                mem_we         = 1'b1;
                                wr_strobe_next = 1'b1;
                                wr_addr_next   = ptr;
                                wr_data_next   = shift;
                                ptr_next       = ptr_inc;
                                state_next     = ACK_WDATA;
                            end
                        endcase
                    end
                end
                ACK_DEV: begin
                    if (scl_fall) begin
                        if (rw) begin
                            state_next = RDATA;
                            sda_t_next = mem_rd[7];
                            shift_next = {mem_rd[6:0], 1'b1};
                        end else begin
                            state_next = WADDR;
                            sda_t_next = 1'b1;
                        end
                    end
                end
                ACK_WADDR, ACK_WDATA: begin
                    if (scl_fall) begin
                        state_next = WDATA;
                        sda_t_next = 1'b1;
                    end
                end
                // The bit sent next sits in shift[7]; rises count how many the controller has sampled.
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_done_next = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            state_next     = MACK;
                            sda_t_next     = 1'b1;
                            ptr_next       = ptr_inc;
                            bit_cnt_next   = 3'd0;
                            byte_done_next = 1'b0;
                        end else begin
                            sda_t_next = shift[7];
                            shift_next = {shift[6:0], 1'b1};
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            state_next = RDATA;
                            shift_next = mem_rd;
                        end else begin
                            state_next = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_fram_target.sv
// Directed bench driving an I2C controller model against the FRAM target, scoreboarded reads and writes.
module tb_i2c_fram_target;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_o, sda_t, busy, wr_strobe;
    logic [7:0] wr_addr, wr_data;

    int passed = 0;
    int total  = 0;

    logic [15:0] exp_wr [$];
    logic [15:0] got_wr [$];
    logic [7:0]  exp_rd [$];

    // Open-drain bus: either side can only pull SDA low.
    assign sda_bus = sda_m & (sda_t | sda_o);

    i2c_fram_target dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) got_wr.push_back({wr_addr, wr_data});
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        assert (got === exp) begin
            passed = passed + 1;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_read(input string tag, input logic [7:0] got);
        logic [7:0] e;
        e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 8'hxx;
        check_output(tag, 16'(got), 16'(e));
    endtask

    task automatic check_writes(input string tag);
        check_output({tag, "_wr_count"}, 16'(got_wr.size()), 16'(exp_wr.size()));
        while (exp_wr.size() > 0 && got_wr.size() > 0)
            check_output({tag, "_wr"}, got_wr.pop_front(), exp_wr.pop_front());
        exp_wr.delete();
        got_wr.delete();
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl = 1'b1; wait_clks(8);
        sda_m = 1'b0; wait_clks(8);
        scl = 1'b0; wait_clks(4);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_clks(4);
        scl = 1'b1; wait_clks(8);
        sda_m = 1'b0; wait_clks(8);
        scl = 1'b0; wait_clks(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(4);
        scl = 1'b1; wait_clks(8);
        sda_m = 1'b1; wait_clks(8);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wait_clks(4);
        scl = 1'b1; wait_clks(8);
        scl = 1'b0; wait_clks(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_clks(4);
        scl = 1'b1; wait_clks(4);
        ack = sda_bus; wait_clks(4);
        scl = 1'b0; wait_clks(4);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_clks(4);
            scl = 1'b1; wait_clks(4);
            d[i] = sda_bus; wait_clks(4);
            scl = 1'b0; wait_clks(4);
        end
        send_bit(ack);
    endtask

    // Writes n bytes (first byte in data[31:24]) starting at word a, expecting every byte acknowledged.
    task automatic write_txn(input string tag, input logic [7:0] a, input logic [31:0] data, input int n);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        send_byte(8'hA0, ack); check_output({tag, "_dev_ack"}, 16'(ack), 16'h0);
        send_byte(a, ack);     check_output({tag, "_addr_ack"}, 16'(ack), 16'h0);
        for (int i = 0; i < n; i++) begin
            b = data[31 - 8 * i -: 8];
            exp_wr.push_back({8'(a + 8'(i)), b});
            send_byte(b, ack);
            check_output({tag, "_data_ack"}, 16'(ack), 16'h0);
        end
        i2c_stop();
    endtask

    // Random read of n bytes from word a; expected bytes are queued by the caller.
    task automatic rand_read(input string tag, input logic [7:0] a, input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        send_byte(8'hA0, ack); check_output({tag, "_dev_ack"}, 16'(ack), 16'h0);
        send_byte(a, ack);     check_output({tag, "_addr_ack"}, 16'(ack), 16'h0);
        i2c_rstart();
        send_byte(8'hA1, ack); check_output({tag, "_rd_ack"}, 16'(ack), 16'h0);
        for (int i = 0; i < n; i++) begin
            recv_byte(d, (i == n - 1));
            check_read({tag, "_rd"}, d);
        end
        i2c_stop();
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;

        $display("[TB] reset");
        wait_clks(5);
        check_output("rst_sda_t", 16'(sda_t), 16'h1);
        check_output("rst_sda_o", 16'(sda_o), 16'h0);
        check_output("rst_busy", 16'(busy), 16'h0);
        check_output("rst_wr_strobe", 16'(wr_strobe), 16'h0);
        check_output("rst_wr_addr", 16'(wr_addr), 16'h0);
        check_output("rst_wr_data", 16'(wr_data), 16'h0);
        rst = 1'b0;
        wait_clks(5);

        $display("[TB] single write and random read");
        i2c_start();
        send_byte(8'hA0, ack); check_output("t1_dev_ack", 16'(ack), 16'h0);
        check_output("t1_busy", 16'(busy), 16'h1);
        send_byte(8'h04, ack); check_output("t1_addr_ack", 16'(ack), 16'h0);
        exp_wr.push_back({8'h04, 8'hA5});
        send_byte(8'hA5, ack); check_output("t1_data_ack", 16'(ack), 16'h0);
        i2c_stop();
        check_output("t1_busy_after_stop", 16'(busy), 16'h0);
        check_writes("t1");
        exp_rd.push_back(8'hA5);
        rand_read("t1", 8'h04, 1);

        $display("[TB] sequential write and read across the wrap");
        write_txn("t2", 8'hFE, 32'h11223344, 4);
        check_writes("t2");
        exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
        exp_rd.push_back(8'h33); exp_rd.push_back(8'h44);
        rand_read("t2", 8'hFE, 4);

        $display("[TB] foreign device address");
        i2c_start();
        send_byte(8'hA2, ack); check_output("t3_nack", 16'(ack), 16'h1);
        check_output("t3_busy", 16'(busy), 16'h0);
        send_byte(8'h04, ack);
        send_byte(8'h5A, ack);
        i2c_stop();
        check_writes("t3");
        exp_rd.push_back(8'hA5);
        rand_read("t3", 8'h04, 1);

        $display("[TB] controller NACK ends the read");
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h00, ack);
        i2c_rstart();
        send_byte(8'hA1, ack); check_output("t4_rd_ack", 16'(ack), 16'h0);
        exp_rd.push_back(8'h33);
        recv_byte(d, 1'b1); check_read("t4_rd", d);
        recv_byte(d, 1'b1); check_output("t4_no_drive", 16'(d), 16'h00FF);
        check_output("t4_busy_held", 16'(busy), 16'h1);
        i2c_stop();
        check_output("t4_busy_after_stop", 16'(busy), 16'h0);

        $display("[TB] reset during a data byte");
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h00, ack);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        sda_m = 1'b0; wait_clks(4);
        scl = 1'b1; wait_clks(4);
        rst = 1'b1;
        #1;
        check_output("t5_sda_t", 16'(sda_t), 16'h1);
        check_output("t5_busy", 16'(busy), 16'h0);
        sda_m = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(8);
        check_writes("t5");
        i2c_start();
        send_byte(8'hA1, ack); check_output("t5_cur_rd_ack", 16'(ack), 16'h0);
        exp_rd.push_back(8'h33);
        recv_byte(d, 1'b1); check_read("t5_cur_rd", d);
        i2c_stop();

        $display("[TB] reset while the target drives ACK");
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(8'hA0 >> i);
        sda_m = 1'b1; wait_clks(4);
        scl = 1'b1; wait_clks(4);
        check_output("t5b_ack_drive", 16'(sda_t), 16'h0);
        rst = 1'b1;
        #1;
        check_output("t5b_async_release", 16'(sda_t), 16'h1);
        wait_clks(4);
        rst = 1'b0;
        wait_clks(8);

        $display("[TB] repeated START aborts a data byte");
        write_txn("t6w", 8'h10, 32'h5C000000, 1);
        check_writes("t6w");
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h10, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i2c_rstart();
        send_byte(8'hA1, ack); check_output("t6_rd_ack", 16'(ack), 16'h0);
        exp_rd.push_back(8'h5C);
        recv_byte(d, 1'b1); check_read("t6_rd", d);
        i2c_stop();
        check_writes("t6");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
